seq_limb_multiplier: RTL and testbench
======================================

Name: seq_limb_multiplier

Overview:
Parametrised, multi-cycle integer multiplier with an optional accumulator, for the distance and centroid datapath of the k-means core.
- Splits each WIDTH-bit operand into LIMB-bit limbs.
- Computes one limb×limb partial product per cycle and sums them into a full 2*WIDTH product.
- Adds signed/unsigned mode, valid/ready handshakes and multiply-accumulate for squared-distance sums.

Parameters:
WIDTH, 16, operand width in bits; must be an integer multiple of LIMB.
LIMB, 8, limb width; one LIMB×LIMB multiply is performed per cycle.
ACC_W, 48, accumulator width; must be ≥ 2*WIDTH.

Ports:
clk  input  1  clock, rising edge
rst  input  1  reset, asynchronous, active-high
in_valid  input  1  operands valid
in_ready  output  1  block can accept operands
a  input  WIDTH  multiplicand
b  input  WIDTH  multiplier
is_signed  input  1  1 = two's-complement operands, 0 = unsigned; sampled with a/b
acc_mode  input  1  1 = add this result to the accumulator; sampled with a/b
acc_clr  input  1  synchronous clear of the accumulator
out_valid  output  1  product (and acc, if acc_mode) valid
out_ready  input  1  consumer accepts the result
product  output  2*WIDTH  registered result
acc  output  ACC_W  registered accumulator
busy  output  1  state ≠ IDLE

Behaviour:
- Notation: N = WIDTH/LIMB.
- Reset (async, rst=1):
  - state=IDLE; product=0; acc=0; out_valid=0; busy=0.
  - in_ready=1, since it is decoded from IDLE.
- States:
  - IDLE: in_ready=1. On in_valid&in_ready, capture a, b, is_signed and acc_mode, then go to MUL.
    - Unsigned operands are taken as-is.
    - Signed operands are replaced by their magnitudes (|−2^(WIDTH−1)| = 2^(WIDTH−1) fits unsigned).
    - Result sign = a[MSB]^b[MSB] when signed, else 0.
    - Internal sum cleared; limb counters i=j=0.
  - MUL: exactly N*N cycles.
    - Each cycle: sum += (a_limb[i]*b_limb[j]) << (LIMB*(i+j)).
    - j is inner, i is outer; MUL → FIN after the last pair.
    - The internal sum is 2*WIDTH bits and never overflows.
  - FIN: one cycle.
    - product <= sign ? −sum : sum (two's complement, 2*WIDTH bits).
    - If acc_mode: acc <= acc + sext(product) when signed, or acc + zext(product) when unsigned; wraps modulo 2^ACC_W with no saturation.
    - Go to DONE.
  - DONE: out_valid=1.
    - product/acc held stable until out_ready=1, then go to IDLE.
    - No new input is accepted in the DONE cycle.
- Latency and throughput:
  - out_valid rises N*N+1 cycles after the accept edge: 5 cycles at the defaults.
  - Minimum initiation interval is N*N+3 cycles.
- product holds its last value between operations; it is never shown as a partial sum.
- acc_clr:
  - Clears acc in any state.
  - If acc_clr coincides with a FIN accumulate, acc <= ext(product) (clear-then-add).
- Inputs are ignored outside IDLE: a/b changing mid-operation has no effect.
- rst asserted mid-operation aborts immediately to reset values; no out_valid pulse for the aborted operation.
- Signed limb arithmetic is never used; all limb products are unsigned.

Test Plan:
1. Unsigned, defaults: a=0xFFFF, b=0xFFFF, is_signed=0 → product=0xFFFE0001; out_valid exactly 5 cycles after accept; in_ready=0 and busy=1 throughout.
2. Signed corner cases, each → result:
   - 0xFFFF×0xFFFF → 0x00000001.
   - 0x8000×0x8000 → 0x40000000.
   - 0x8000×0x0001 → 0xFFFF8000.
   - 0x0000×0x8000 → 0x00000000.
3. MAC, signed:
   - Sequence: acc_clr; then acc_mode=1 for 3×3, 0xFFFE×5 (−2×5), 0x0007×0x0007.
   - Expected acc after each: 9, 0xFFFFFFFFFFFF (−1), 48.
   - A final acc_mode=0 op leaves acc=48.
4. Backpressure: out_ready held 0 for 10 cycles after out_valid → product/acc/out_valid stable and in_valid ignored; one out_ready cycle → IDLE next cycle, in_ready=1.
5. Reset and clear:
   - rst pulsed during MUL cycle 2 → all outputs return to reset values asynchronously; no out_valid afterwards; the next operation 0x1234×0x5678 (unsigned) → 0x0626_0060.
   - acc_clr asserted in the FIN cycle of 3×4 accumulate with acc=100 → acc=12.
6. Parameter sweep: WIDTH=32, LIMB=8 (N=4), a=0xFFFFFFFF, b=0x00000002, unsigned → product=0x1_FFFFFFFE, latency 17 cycles; randomized signed/unsigned vectors checked against a reference model.

Source files
------------

// File: rtl/seq_limb_multiplier.sv
// Multi-cycle limb-serial integer multiplier with optional multiply-accumulate.
// Handles signed and unsigned operands and uses valid/ready handshakes on input and output.
module seq_limb_multiplier #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned LIMB  = 8,
  parameter int unsigned ACC_W = 48
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               is_signed,
  input  logic               acc_mode,
  input  logic               acc_clr,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] product,
  output logic [ACC_W-1:0]   acc,
  output logic               busy
);

  localparam int unsigned N  = WIDTH / LIMB;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, MUL, FIN, DONE} state_t;

  state_t            state;
  logic [WIDTH-1:0]  ma, mb;
  logic              neg, sgn, accm;
  logic [CW-1:0]     li, lj;
  logic [PW-1:0]     sum;

  logic [2*LIMB-1:0] lp_c;
  logic [PW-1:0]     pp_c, res_c;
  logic [ACC_W-1:0]  ext_c, acc_base_c;
  logic [WIDTH-1:0]  abs_a_c, abs_b_c;

  // Datapath: current unsigned limb product, final signed result, accumulator addend.
  always_comb begin
    lp_c       = ma[LIMB*li +: LIMB] * mb[LIMB*lj +: LIMB];
    pp_c       = PW'(lp_c) << (LIMB * (32'(li) + 32'(lj)));
    res_c      = neg ? -sum : sum;
    ext_c      = sgn ? ACC_W'($signed(res_c)) : ACC_W'(res_c);
    acc_base_c = acc_clr ? '0 : acc;
    abs_a_c    = (is_signed && a[WIDTH-1]) ? -a : a;
    abs_b_c    = (is_signed && b[WIDTH-1]) ? -b : b;
  end

  // Control FSM with registered handshake and result outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      product   <= '0;
      acc       <= '0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      ma        <= '0;
      mb        <= '0;
      neg       <= 1'b0;
      sgn       <= 1'b0;
      accm      <= 1'b0;
      li        <= '0;
      lj        <= '0;
      sum       <= '0;
    end else begin
      if (acc_clr) acc <= '0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            ma       <= abs_a_c;
            mb       <= abs_b_c;
            sgn      <= is_signed;
            neg      <= is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
            accm     <= acc_mode;
            sum      <= '0;
            li       <= '0;
            lj       <= '0;
            in_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= MUL;
          end
        end
        MUL: begin
          sum <= sum + pp_c;
          if (lj == CW'(N - 1)) begin
            lj <= '0;
            if (li == CW'(N - 1)) state <= FIN;
            else                  li <= li + CW'(1);
          end else begin
            lj <= lj + CW'(1);
          end
        end
        FIN: begin
          product   <= res_c;
          // A coincident clear makes this result the new accumulator base.
          if (accm) acc <= acc_base_c + ext_c;
          out_valid <= 1'b1;
          state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            busy      <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_limb_multiplier.sv
// Randomised self-checking bench for seq_limb_multiplier at 16/8 and 32/8 configurations.
module tb_seq_limb_multiplier;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // 16-bit instance (defaults)
  logic        iv16, ir16, s16, m16, clr16, ov16, or16, busy16;
  logic [15:0] a16, b16;
  logic [31:0] p16;
  logic [47:0] acc16;

  // 32-bit instance
  logic        iv32, ir32, s32, m32, clr32, ov32, or32, busy32;
  logic [31:0] a32, b32;
  logic [63:0] p32;
  logic [63:0] acc32;

  seq_limb_multiplier dut16 (
    .clk(clk), .rst(rst), .in_valid(iv16), .in_ready(ir16), .a(a16), .b(b16),
    .is_signed(s16), .acc_mode(m16), .acc_clr(clr16), .out_valid(ov16),
    .out_ready(or16), .product(p16), .acc(acc16), .busy(busy16)
  );

  seq_limb_multiplier #(.WIDTH(32), .LIMB(8), .ACC_W(64)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv32), .in_ready(ir32), .a(a32), .b(b32),
    .is_signed(s32), .acc_mode(m32), .acc_clr(clr32), .out_valid(ov32),
    .out_ready(or32), .product(p32), .acc(acc32), .busy(busy32)
  );

  int n_chk  = 0;
  int n_fail = 0;
  logic [47:0] acc_m16 = '0;
  logic [63:0] acc_m32 = '0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference product: plain integer multiply of the operands interpreted per mode.
  function automatic logic [31:0] ref16(input logic [15:0] x, input logic [15:0] y, input bit s);
    longint lx, ly;
    lx = s ? longint'($signed(x)) : longint'({48'b0, x});
    ly = s ? longint'($signed(y)) : longint'({48'b0, y});
    return 32'(lx * ly);
  endfunction

  function automatic logic [63:0] ref32(input logic [31:0] x, input logic [31:0] y, input bit s);
    longint lx, ly;
    lx = s ? longint'($signed(x)) : longint'({32'b0, x});
    ly = s ? longint'($signed(y)) : longint'({32'b0, y});
    return 64'(lx * ly);
  endfunction

  task automatic op16(input logic [15:0] ta, input logic [15:0] tb, input bit ts, input bit tm,
                      input int hold, input int clr_at);
    logic [31:0] ep, sp;
    logic [47:0] sa;
    int lat;
    bit bad_ctl, bad_hold;
    ep = ref16(ta, tb, ts);
    if (clr_at >= 0) acc_m16 = '0;
    if (tm) acc_m16 = acc_m16 + (ts ? {{16{ep[31]}}, ep} : {16'b0, ep});
    @(negedge clk);
    chk("in_ready_idle", 64'(ir16), 64'd1);
    a16 = ta; b16 = tb; s16 = ts; m16 = tm; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0; a16 = 16'($urandom); b16 = 16'($urandom); s16 = ~ts; m16 = ~tm;
    lat = 0; bad_ctl = 0;
    while (!ov16 && lat < 100) begin
      if (ir16 || !busy16) bad_ctl = 1;
      @(posedge clk); #1;
      lat++;
      clr16 = (lat == clr_at);
    end
    clr16 = 1'b0;
    chk("busy_inready_during_op", 64'(bad_ctl), 64'd0);
    chk("latency16", 64'(lat), 64'd5);
    chk("product16", 64'(p16), 64'(ep));
    chk("acc16", 64'(acc16), 64'(acc_m16));
    sp = p16; sa = acc16; bad_hold = 0;
    for (int k = 0; k < hold; k++) begin
      iv16 = 1'b1; a16 = 16'($urandom); b16 = 16'($urandom);
      @(posedge clk); #1;
      if (ov16 !== 1'b1 || p16 !== sp || acc16 !== sa || ir16 !== 1'b0) bad_hold = 1;
    end
    iv16 = 1'b0;
    chk("hold_stable", 64'(bad_hold), 64'd0);
    or16 = 1'b1;
    @(posedge clk); #1;
    or16 = 1'b0;
    chk("out_valid_drop", 64'(ov16), 64'd0);
    chk("in_ready_back", 64'(ir16), 64'd1);
  endtask

  task automatic op32(input logic [31:0] ta, input logic [31:0] tb, input bit ts, input bit tm);
    logic [63:0] ep;
    int lat;
    ep = ref32(ta, tb, ts);
    if (tm) acc_m32 = acc_m32 + ep;
    @(negedge clk);
    a32 = ta; b32 = tb; s32 = ts; m32 = tm; iv32 = 1'b1;
    @(posedge clk); #1;
    iv32 = 1'b0; a32 = $urandom; b32 = $urandom;
    lat = 0;
    while (!ov32 && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("latency32", 64'(lat), 64'd17);
    chk("product32", p32, ep);
    chk("acc32", acc32, acc_m32);
    or32 = 1'b1;
    @(posedge clk); #1;
    or32 = 1'b0;
    chk("in_ready32_back", 64'(ir32), 64'd1);
  endtask

  task automatic clear16();
    @(negedge clk);
    clr16 = 1'b1;
    @(posedge clk); #1;
    clr16 = 1'b0;
    acc_m16 = '0;
    chk("acc_clr_idle", 64'(acc16), 64'd0);
  endtask

  initial begin
    bit seen;
    rst = 1'b1;
    iv16 = 0; a16 = 0; b16 = 0; s16 = 0; m16 = 0; clr16 = 0; or16 = 0;
    iv32 = 0; a32 = 0; b32 = 0; s32 = 0; m32 = 0; clr32 = 0; or32 = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_product", 64'(p16), 64'd0);
    chk("rst_acc", 64'(acc16), 64'd0);
    chk("rst_out_valid", 64'(ov16), 64'd0);
    chk("rst_busy", 64'(busy16), 64'd0);
    chk("rst_in_ready", 64'(ir16), 64'd1);
    @(negedge clk);
    rst = 1'b0;

    op16(16'hFFFF, 16'hFFFF, 0, 0, 0, -1);
    chk("ffff_sq_const", 64'(p16), 64'hFFFE0001);

    op16(16'hFFFF, 16'hFFFF, 1, 0, 0, -1);
    op16(16'h8000, 16'h8000, 1, 0, 0, -1);
    op16(16'h8000, 16'h0001, 1, 0, 0, -1);
    op16(16'h0000, 16'h8000, 1, 0, 0, -1);

    clear16();
    op16(16'h0003, 16'h0003, 1, 1, 0, -1);
    op16(16'hFFFE, 16'h0005, 1, 1, 0, -1);
    chk("mac_minus1", 64'(acc16), 64'hFFFFFFFFFFFF);
    op16(16'h0007, 16'h0007, 1, 1, 0, -1);
    op16(16'h0005, 16'h0005, 1, 0, 0, -1);
    chk("mac_final48", 64'(acc16), 64'd48);

    op16(16'($urandom), 16'($urandom), 1'($urandom), 1, 10, -1);

    // Abort mid-multiply with an async reset pulse.
    @(negedge clk);
    a16 = 16'h1111; b16 = 16'h2222; s16 = 0; m16 = 1; iv16 = 1'b1;
    @(posedge clk); #1;
    iv16 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    #2;
    chk("abort_product", 64'(p16), 64'd0);
    chk("abort_acc", 64'(acc16), 64'd0);
    chk("abort_busy", 64'(busy16), 64'd0);
    chk("abort_in_ready", 64'(ir16), 64'd1);
    rst = 1'b0;
    acc_m16 = '0; acc_m32 = '0;
    seen = 0;
    repeat (10) begin
      @(posedge clk); #1;
      if (ov16) seen = 1;
    end
    chk("abort_no_out_valid", 64'(seen), 64'd0);
    op16(16'h1234, 16'h5678, 0, 0, 0, -1);
    chk("post_abort_const", 64'(p16), 64'h06260060);

    clear16();
    op16(16'd10, 16'd10, 0, 1, 0, -1);
    op16(16'd3, 16'd4, 0, 1, 0, 4);
    chk("clr_in_fin_12", 64'(acc16), 64'd12);

    op32(32'hFFFFFFFF, 32'h00000002, 0, 0);
    chk("w32_const", p32, 64'h1FFFFFFFE);
    for (int n = 0; n < 20; n++) op32($urandom, $urandom, 1'($urandom), 1'($urandom));
    for (int n = 0; n < 30; n++)
      op16(16'($urandom), 16'($urandom), 1'($urandom), 1'($urandom),
           int'($urandom_range(0, 3)), ($urandom_range(0, 7) == 0) ? 4 : -1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
